// File: rtl/glyph_pkg.sv
// Shared constants and FSM state type for the glyph fetch/serialiser block.
package glyph_pkg;

  localparam int CODE_W_DEF = 8;
  localparam int ROWS_DEF   = 16;
  localparam int GLYPH_COLS = 16;
  localparam int ROM_ADDR_W = 12;
  localparam int COL_W      = 4;
  localparam int ROW_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/glyph_row_shifter.sv
// One glyph row: parallel-loaded 16-bit shift register (MSB = leftmost pixel)
// plus the column counter that tracks which pixel is presented.
module glyph_row_shifter
  import glyph_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [GLYPH_COLS-1:0] row_data_i,
  output logic                  msb_o,
  output logic [COL_W-1:0]      col_o,
  output logic                  col_last_o
);

  logic [GLYPH_COLS-1:0] shift_q, shift_d;
  logic [COL_W-1:0]      col_q, col_d;

  always_comb begin
    shift_d = shift_q;
    col_d   = col_q;
    if (load_i) begin
      shift_d = row_data_i;
      col_d   = '0;
    end else if (shift_i) begin
      shift_d = {shift_q[GLYPH_COLS-2:0], 1'b0};
      col_d   = col_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      col_q   <= '0;
    end else begin
      shift_q <= shift_d;
      col_q   <= col_d;
    end
  end

  assign msb_o      = shift_q[GLYPH_COLS-1];
  assign col_o      = col_q;
  assign col_last_o = (col_q == COL_W'(GLYPH_COLS - 1));

endmodule

// File: rtl/glyph_fetch.sv
// Glyph renderer: fetches font ROM rows for a requested code and streams the
// pixels out one per accepted beat. Optional per-glyph inversion: GLYPH_FETCH_INVERT_EN.
module glyph_fetch
  import glyph_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int ROWS   = ROWS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [CODE_W-1:0]     req_code,
`ifdef GLYPH_FETCH_INVERT_EN
  input  logic                  req_invert,
`endif
  output logic                  req_ready,
  output logic [ROM_ADDR_W-1:0] addra,
  input  logic [GLYPH_COLS-1:0] douta,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_data,
  output logic [COL_W-1:0]      pix_x,
  output logic [ROW_W-1:0]      pix_y,
  output logic                  pix_last,
  output logic                  busy
);

  state_e            state_q, state_d;
  logic              rdy_q;
  logic [CODE_W-1:0] code_q, code_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              inv_q, inv_d;

  logic              handshake;
  logic              row_last;
  logic              load_row;
  logic              shift_en;
  logic              msb;
  logic [COL_W-1:0]  col;
  logic              col_last;

  assign handshake = req_valid && req_ready;
  assign row_last  = (row_q == ROW_W'(ROWS - 1));

  // rdy_q holds req_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (handshake) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_SHIFT;
      ST_SHIFT: if (pix_ready && col_last) state_d = row_last ? ST_IDLE : ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE) && rdy_q;
    pix_valid = (state_q == ST_SHIFT);
    busy      = (state_q != ST_IDLE);
    load_row  = (state_q == ST_FETCH);
    shift_en  = (state_q == ST_SHIFT) && pix_ready;
    pix_last  = (state_q == ST_SHIFT) && col_last && row_last;
  end

  always_comb begin
    code_d = code_q;
    row_d  = row_q;
    inv_d  = inv_q;
    if (handshake) begin
      code_d = req_code;
      row_d  = '0;
`ifdef GLYPH_FETCH_INVERT_EN
      inv_d  = req_invert;
`else
      inv_d  = 1'b0;
`endif
    end else if (shift_en && col_last && !row_last) begin
      row_d  = row_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      row_q  <= '0;
      inv_q  <= 1'b0;
    end else begin
      code_q <= code_d;
      row_q  <= row_d;
      inv_q  <= inv_d;
    end
  end

  glyph_row_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_row),
    .shift_i    (shift_en),
    .row_data_i (douta),
    .msb_o      (msb),
    .col_o      (col),
    .col_last_o (col_last)
  );

  // Address comes only from registered code/row, never from req_code
  assign addra = ROM_ADDR_W'({code_q, row_q});
  assign pix_x = col;
  assign pix_y = row_q;

`ifdef GLYPH_FETCH_INVERT_EN
  assign pix_data = pix_valid && (msb ^ inv_q);
`else
  assign pix_data = pix_valid && msb && !inv_q;
`endif

endmodule

// File: tb/tb_glyph_fetch.sv
// Self-checking bench for glyph_fetch with a behavioural ROM and pixel model.
module tb_glyph_fetch;

  localparam int ROWS = 16;
  localparam int NPIX = ROWS * 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [7:0]  req_code;
`ifdef GLYPH_FETCH_INVERT_EN
  logic        req_invert;
`endif
  logic        req_ready;
  logic [11:0] addra;
  logic [15:0] douta;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_data;
  logic [3:0]  pix_x;
  logic [3:0]  pix_y;
  logic        pix_last;
  logic        busy;

  logic [15:0] rom [4096];
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign douta = rom[addra];

  glyph_fetch #(.CODE_W(8), .ROWS(ROWS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_code  (req_code),
`ifdef GLYPH_FETCH_INVERT_EN
    .req_invert(req_invert),
`endif
    .req_ready (req_ready),
    .addra     (addra),
    .douta     (douta),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_last  (pix_last),
    .busy      (busy)
  );

  // Entered at a negedge. mode: 0 ready always, 1 toggling, 2 random.
  task automatic render(input logic [7:0] code, input int mode, input bit inv,
                        input bit keep, input logic [7:0] next_code,
                        input bit chk_time, input bit imm);
    int idx, cyc, wait_c, first_v, busy_cyc;
    bit stalled;
    logic [11:0] last_addr, s_addr, exp_addr;
    logic [15:0] w;
    logic s_d, s_l, exp_d;
    logic [3:0] s_x, s_y;
    req_valid = 1'b1;
    req_code  = code;
`ifdef GLYPH_FETCH_INVERT_EN
    req_invert = inv;
`endif
    wait_c = 0;
    while (req_ready !== 1'b1 && wait_c < 2000) begin
      @(negedge clk);
      wait_c++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_wait code=%h got ready=%b want 1", code, req_ready);
      req_valid = 1'b0;
      return;
    end
    if (imm) begin
      n_cmp++;
      if (wait_c != 0) begin
        n_fail++;
        $display("FAIL b2b_gap got %0d wait cycles want 0", wait_c);
      end
    end
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
    else req_code = next_code;
    n_cmp++;
    if (pix_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_cycle got valid=%b busy=%b want 0/1", pix_valid, busy);
    end
    idx = 0; cyc = 1; first_v = -1; busy_cyc = 0; stalled = 0; last_addr = '0;
    s_addr = '0; s_d = 0; s_l = 0; s_x = '0; s_y = '0;
    while (busy === 1'b1 && cyc < 3000) begin
      busy_cyc++;
      n_cmp++;
      if (req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_busy cyc=%0d got %b want 0", cyc, req_ready);
      end
      if (stalled) begin
        n_cmp++;
        if (pix_valid !== 1'b1 || pix_data !== s_d || pix_x !== s_x || pix_y !== s_y ||
            pix_last !== s_l || addra !== s_addr) begin
          n_fail++;
          $display("FAIL stall_hold cyc=%0d got v%b d%b x%0d y%0d l%b a%h want v1 d%b x%0d y%0d l%b a%h",
                   cyc, pix_valid, pix_data, pix_x, pix_y, pix_last, addra, s_d, s_x, s_y, s_l, s_addr);
        end
      end
      case (mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = (cyc % 2 == 1);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      if (pix_valid === 1'b1) begin
        if (first_v < 0) first_v = cyc;
        if (pix_ready) begin
          w        = rom[{code, 4'(idx / 16)}];
          exp_d    = w[15 - (idx % 16)] ^ inv;
          exp_addr = {code, 4'(idx / 16)};
          n_cmp++;
          if (pix_data !== exp_d || pix_x !== 4'(idx % 16) || pix_y !== 4'(idx / 16) ||
              pix_last !== (idx == NPIX - 1) || addra !== exp_addr) begin
            n_fail++;
            $display("FAIL pixel code=%h idx=%0d got d%b x%0d y%0d l%b a%h want d%b x%0d y%0d l%b a%h",
                     code, idx, pix_data, pix_x, pix_y, pix_last, addra,
                     exp_d, idx % 16, idx / 16, (idx == NPIX - 1), exp_addr);
          end
          if (pix_last === 1'b1) last_addr = addra;
          idx++;
          stalled = 0;
        end else begin
          stalled = 1;
          s_d = pix_data; s_x = pix_x; s_y = pix_y; s_l = pix_last; s_addr = addra;
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (idx != NPIX || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pixel_count code=%h got %0d busy=%b want %0d busy=0", code, idx, busy, NPIX);
    end
    n_cmp++;
    if (first_v != 2) begin
      n_fail++;
      $display("FAIL latency got %0d want 2", first_v);
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after got %b want 1", req_ready);
    end
    n_cmp++;
    if (last_addr !== {code, 4'(ROWS - 1)}) begin
      n_fail++;
      $display("FAIL last_addr got %h want %h", last_addr, {code, 4'(ROWS - 1)});
    end
    if (chk_time) begin
      n_cmp++;
      if (busy_cyc != ROWS * 17) begin
        n_fail++;
        $display("FAIL glyph_time got %0d want %0d", busy_cyc, ROWS * 17);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_code = '0; pix_ready = 1'b0;
`ifdef GLYPH_FETCH_INVERT_EN
    req_invert = 1'b0;
`endif
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({req_ready, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, addra} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got rdy%b v%b d%b x%h y%h l%b b%b a%h want all 0",
               req_ready, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, addra);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got rdy%b busy%b want 1/0", req_ready, busy);
    end
  endtask

  task automatic test_pattern();
    render(8'h41, 0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_stall_toggle();
    render(8'h41, 1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      render(8'($urandom_range(0, 255)), 2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    render(8'h5A, 0, 1'b0, 1'b1, b, 1'b0, 1'b0);
    render(b, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_last_code();
    render(8'hFF, 0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_reset_abort();
    int guard;
    req_valid = 1'b1; req_code = 8'($urandom_range(1, 255)); pix_ready = 1'b1;
    guard = 0;
    while (!(pix_valid === 1'b1 && pix_y === 4'd7 && pix_x === 4'd5) && guard < 500) begin
      @(negedge clk);
      if (req_ready !== 1'b1) req_valid = 1'b0;
      guard++;
    end
    req_valid = 1'b0;
    n_cmp++;
    if (guard >= 500) begin
      n_fail++;
      $display("FAIL abort_reach got y%0d x%0d want y7 x5", pix_y, pix_x);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, addra} !== '0) begin
      n_fail++;
      $display("FAIL abort_async got rdy%b v%b d%b x%h y%h l%b b%b a%h want all 0",
               req_ready, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, addra);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (pix_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_hold got v%b b%b want 0/0", pix_valid, busy);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_rdy_early got %b want 0", req_ready);
    end
    @(negedge clk);
    render(8'h00, 0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

`ifdef GLYPH_FETCH_INVERT_EN
  task automatic test_invert();
    render(8'h22, 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    render(8'h22, 2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 16'($urandom);
    for (int r = 0; r < 16; r++) begin
      rom[{8'h41, 4'(r)}] = 16'h8001;
      rom[{8'h22, 4'(r)}] = 16'hFFFF;
    end
    test_reset();
    test_pattern();
    test_stall_toggle();
    test_random();
    test_back_to_back();
    test_last_code();
    test_reset_abort();
`ifdef GLYPH_FETCH_INVERT_EN
    test_invert();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
